// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter.
// Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one
// bit per clock. frame_out marks valid bits and first_out marks the first bit
// of each word. An optional idle gap of GAP cycles follows every word; with
// GAP == 0, words stream back to back with no bubble.
module piso_serializer #(
  parameter int WIDTH     = 8,   // 2..32
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0    // 0..15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             data_out,
  output logic             frame_out,
  output logic             first_out,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [3:0]       GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic [3:0]       gap_cnt;

  logic [WIDTH-1:0] shift_next;  // register after moving one bit toward the send end
  logic             next_bit;    // bit that reaches the send end after that move
  logic             load_bit;    // first bit of a freshly accepted word
  logic             accept;

  // Select the shift direction once at elaboration; only one branch exists in hardware.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shift_next = {shift_reg[WIDTH-2:0], 1'b0};
      assign next_bit   = shift_reg[WIDTH-2];
      assign load_bit   = data_in[WIDTH-1];
    end else begin : g_lsb_first
      assign shift_next = {1'b0, shift_reg[WIDTH-1:1]};
      assign next_bit   = shift_reg[1];
      assign load_bit   = data_in[0];
    end
  endgenerate

  // Ready in IDLE, or on the last bit of a word when streaming without a gap.
  // Forced low while reset is asserted so a load in that cycle is ignored.
  assign load_ready = !reset &&
                      ((state == ST_IDLE) ||
                       ((GAP == 0) && (state == ST_SHIFT) && (bit_cnt == BIT_LAST)));

  assign accept = load_valid && load_ready;

  // Single FSM: state, shift register, counters and all serial outputs are registered.
  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      data_out  <= 1'b0;
      frame_out <= 1'b0;
      first_out <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SHIFT;
            shift_reg <= data_in;
            bit_cnt   <= '0;
            data_out  <= load_bit;
            frame_out <= 1'b1;
            first_out <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (bit_cnt != BIT_LAST) begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt + CNT_W'(1);
            data_out  <= next_bit;
            first_out <= 1'b0;
          end else if (accept) begin
            // Back-to-back reload: next word's first bit follows immediately.
            shift_reg <= data_in;
            bit_cnt   <= '0;
            data_out  <= load_bit;
            first_out <= 1'b1;
          end else if (GAP == 0) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            data_out  <= 1'b0;
            frame_out <= 1'b0;
            first_out <= 1'b0;
            busy      <= 1'b0;
          end else begin
            state     <= ST_GAP;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            data_out  <= 1'b0;
            frame_out <= 1'b0;
            first_out <= 1'b0;
          end
        end

        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          data_out  <= 1'b0;
          frame_out <= 1'b0;
          first_out <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer. Four instances with different bit orders and
// gap lengths run side by side. Each has a reference model that turns every
// accepted word into a queue of expected output cycles (WIDTH data bits
// followed by GAP idle-but-busy cycles); outputs are compared every cycle.
module tb_piso_serializer;

  localparam int W = 8;
  localparam int N = 4;
  // Per-instance configuration: bit g of CFG_MF, nibble g of CFG_GAP.
  localparam logic [N-1:0]   CFG_MF  = 4'b1101;
  localparam logic [4*N-1:0] CFG_GAP = {4'd2, 4'd3, 4'd0, 4'd0};

  typedef struct packed {
    logic d;  // expected data_out
    logic f;  // expected frame_out
    logic s;  // expected first_out
  } ent_t;

  logic             clk = 1'b0;
  logic [N-1:0]     rst;
  logic [N-1:0]     vld;
  logic [W-1:0]     din [N];
  logic [N-1:0]     rdy, dout, frame, first, busy;
  logic             chk_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_u
    localparam bit MF = CFG_MF[g];
    localparam int GP = int'(CFG_GAP[g*4 +: 4]);

    piso_serializer #(.WIDTH(W), .MSB_FIRST(MF), .GAP(GP)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .data_in    (din[g]),
      .load_valid (vld[g]),
      .load_ready (rdy[g]),
      .data_out   (dout[g]),
      .frame_out  (frame[g]),
      .first_out  (first[g]),
      .busy       (busy[g])
    );

    ent_t        q[$];
    int          nframe = 0;
    int          nfirst = 0;
    int          ngap   = 0;
    int          run    = 0;
    int          maxrun = 0;
    logic [31:0] cap    = '0;

    // Compare on the falling edge, then advance the model to the next rising edge.
    always @(negedge clk) begin
      ent_t         cur;
      logic         exp_rdy;
      logic [W-1:0] w;
      if (chk_en) begin
        cur     = (q.size() > 0) ? q[0] : '0;
        exp_rdy = !rst[g] && ((q.size() == 0) || (GP == 0 && q.size() == 1));
        check($sformatf("u%0d.data_out", g),   dout[g],  cur.d);
        check($sformatf("u%0d.frame_out", g),  frame[g], cur.f);
        check($sformatf("u%0d.first_out", g),  first[g], cur.s);
        check($sformatf("u%0d.busy", g),       busy[g],  q.size() != 0);
        check($sformatf("u%0d.load_ready", g), rdy[g],   exp_rdy);

        if (frame[g]) begin
          nframe++;
          cap = {cap[30:0], dout[g]};
          run++;
          if (run > maxrun) maxrun = run;
        end else begin
          run = 0;
        end
        if (first[g]) nfirst++;
        if (busy[g] && !frame[g]) ngap++;

        if (rst[g]) begin
          q.delete();
        end else begin
          if (q.size() > 0) void'(q.pop_front());
          if (vld[g] && exp_rdy) begin
            w = din[g];
            for (int i = 0; i < W; i++)
              q.push_back('{d: (MF ? w[W-1-i] : w[i]), f: 1'b1, s: (i == 0)});
            for (int j = 0; j < GP; j++)
              q.push_back('0);
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int f0, s0;
    rst = '1;
    vld = '0;
    for (int g = 0; g < N; g++) din[g] = '0;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    rst = '0;
    cyc(1);

    // Phase 1: single words on every instance; u2 gets two queued words,
    // u3 sees load_valid pulses while shifting and while in the gap.
    vld    = '1;
    din[0] = 8'hA5;
    din[1] = 8'h1E;
    din[2] = 8'h81;
    din[3] = 8'h5A;
    cyc(1);
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    din[2] = 8'h7E;
    vld[3] = 1'b0;
    din[3] = 8'hFF;
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      vld[2] = (i < 12);
      vld[3] = ((i >= 2 && i <= 5) || i == 8 || i == 9);
    end
    check("msb_first_a5",   g_u[0].cap[7:0],  32'hA5);
    check("msb_frame_len",  g_u[0].nframe,    32'd8);
    check("msb_first_cnt",  g_u[0].nfirst,    32'd1);
    check("lsb_first_1e",   g_u[1].cap[7:0],  32'h78);
    check("lsb_frame_len",  g_u[1].nframe,    32'd8);
    check("gap3_words",     g_u[2].cap[15:0], 32'h817E);
    check("gap3_frame_len", g_u[2].nframe,    32'd16);
    check("gap3_gap_cyc",   g_u[2].ngap,      32'd6);
    check("gap3_max_run",   g_u[2].maxrun,    32'd8);
    check("busy_load_word", g_u[3].cap[7:0],  32'h5A);
    check("busy_load_len",  g_u[3].nframe,    32'd8);
    check("busy_load_gap",  g_u[3].ngap,      32'd2);

    // Phase 2: back-to-back streaming on u0 with load_valid held high.
    f0     = g_u[0].nframe;
    s0     = g_u[0].nfirst;
    vld[0] = 1'b1;
    din[0] = 8'h81;
    cyc(1);
    din[0] = 8'h7E;
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      vld[0] = (i < 8);
    end
    check("b2b_words",     g_u[0].cap[15:0],   32'h817E);
    check("b2b_frame_len", g_u[0].nframe - f0, 32'd16);
    check("b2b_contig",    g_u[0].maxrun,      32'd16);
    check("b2b_firsts",    g_u[0].nfirst - s0, 32'd2);

    // Phase 3: reset after three bits of 0xFF, with a load attempt during reset.
    f0     = g_u[0].nframe;
    vld[0] = 1'b1;
    din[0] = 8'hFF;
    cyc(1);
    vld[0] = 1'b0;
    cyc(2);
    rst[0] = 1'b1;
    vld[0] = 1'b1;
    din[0] = 8'hAA;
    cyc(1);
    check("rst_data_out", dout[0],  32'd0);
    check("rst_frame",    frame[0], 32'd0);
    check("rst_busy",     busy[0],  32'd0);
    rst[0] = 1'b0;
    vld[0] = 1'b0;
    #1;
    check("rst_ready_back", rdy[0], 32'd1);
    cyc(1);
    vld[0] = 1'b1;
    din[0] = 8'h0F;
    cyc(1);
    vld[0] = 1'b0;
    cyc(12);
    check("post_rst_word",  g_u[0].cap[7:0],   32'h0F);
    check("post_rst_frame", g_u[0].nframe - f0, 32'd11);

    // Phase 4: random traffic with occasional resets, checked by the model each cycle.
    for (int k = 0; k < 3000; k++) begin
      for (int g = 0; g < N; g++) begin
        rst[g] = ($urandom_range(0, 39) == 0);
        vld[g] = $urandom_range(0, 1) == 1;
        din[g] = W'($urandom);
      end
      cyc(1);
    end
    rst = '0;
    vld = '0;
    cyc(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter: the driving end for the team's serial-in shift-register receivers.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per clock.
- Emits frame and first-bit markers so a downstream deserializer can align words.
- Optional inter-word idle gap; back-to-back streaming when the gap is zero.

Parameters:
WIDTH, 8, word width in bits; legal range 2..32
MSB_FIRST, 1, 1 = bit WIDTH-1 sent first; 0 = bit 0 sent first
GAP, 0, idle cycles forced between words; legal range 0..15

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  WIDTH  parallel word to transmit; sampled only on accept
load_valid  input  1  data_in holds a word to send
load_ready  output  1  serializer can accept a word this cycle
data_out  output  1  serial bit stream
frame_out  output  1  high while data_out carries a valid bit
first_out  output  1  high only during the first bit of each word
busy  output  1  high in SHIFT or GAP state

Behaviour:
- Interface (already decided): one clock, clk. Reset port reset is synchronous and active-high.
- FSM states: IDLE, SHIFT, GAP. Registers: shift register (WIDTH), bit counter (clog2(WIDTH)), gap counter (4 bits).
- Reset behaviour:
  - While reset is high at a clk edge: state=IDLE, shift register=0, counters=0.
  - data_out=0, frame_out=0, first_out=0, busy=0.
  - load_ready=0 during any cycle with reset high.
- load_ready (combinational):
  - 1 in IDLE.
  - 1 in SHIFT on the last bit (bit_cnt==WIDTH-1) only when GAP==0.
  - 0 otherwise.
- Accept = load_valid && load_ready at a rising edge.
  - On accept: data_in captured, bit_cnt=0, state=SHIFT.
  - data_in is don't-care on all other cycles.
- Latency: the first bit appears on data_out in the cycle immediately after the accept edge.
- SHIFT:
  - frame_out=1 and busy=1 for exactly WIDTH cycles.
  - first_out=1 only when bit_cnt==0.
  - data_out is the current MSB (MSB_FIRST=1) or LSB (MSB_FIRST=0) of the shift register.
  - The register shifts toward that end each cycle and bit_cnt increments.
- Leaving SHIFT, at the edge ending the last bit:
  - Accept in that cycle (GAP==0 only): reload and stay in SHIFT. The next word's first bit follows with no bubble.
  - No accept and GAP==0: go to IDLE.
  - GAP>0: go to GAP with gap counter=0.
- GAP:
  - frame_out=0, data_out=0, busy=1, load_ready=0.
  - Lasts exactly GAP cycles, then IDLE.
- IDLE: data_out=0, frame_out=0, first_out=0, busy=0.
- Boundary conditions:
  - load_valid while load_ready=0: ignored, nothing captured, no error.
  - The producer may hold or drop load_valid freely.
  - Reset mid-word or mid-gap: the word is discarded and no further bits are emitted. The next cycle shows idle outputs.
  - load_valid high in the same cycle as reset: ignored.
  - Bit counter never exceeds WIDTH-1, and the gap counter never exceeds GAP-1; no wrap beyond them.
- data_out, frame_out and first_out derive only from registered state, so they are glitch-free relative to the inputs.

Test Plan:
- Single word, WIDTH=8, MSB_FIRST=1, data_in=0xA5 accepted at edge N -> cycles N+1..N+8:
  - data_out = 1,0,1,0,0,1,0,1.
  - frame_out=1 for exactly 8 cycles.
  - first_out=1 only at N+1.
  - load_ready=0 during N+1..N+7.
- LSB first, MSB_FIRST=0, data_in=0x1E -> data_out = 0,1,1,1,1,0,0,0, then frame_out=0 and load_ready=1.
- Back-to-back, GAP=0, load_valid held high with 0x81 then 0x7E:
  - 16 contiguous frame_out cycles.
  - data_out = 1,0,0,0,0,0,0,1,0,1,1,1,1,1,1,0.
  - first_out pulses at bits 1 and 9.
- GAP=3, two words queued:
  - Exactly 3 cycles with frame_out=0, busy=1, load_ready=0 between the words.
  - The second word starts the cycle after load_ready returns to 1.
- Reset mid-word: reset asserted after 3 bits of 0xFF ->
  - Next cycle: data_out=0, frame_out=0, busy=0.
  - After release, load_ready=1 and a new word 0x0F transmits cleanly.
- Load while busy, GAP=2: pulse load_valid with 0xFF during SHIFT bits 2..5 and during GAP -> no capture, the current word finishes unchanged, and no extra frame appears.
